// File: rtl/cheshire_pkg.sv
// Shared Cheshire definitions: regbus address map, output enum and arbiter constants.
package cheshire_pkg;

    localparam int unsigned RegbusAddrWidth = 48;
    localparam int unsigned RegbusDataWidth = 32;

    typedef struct packed {
        logic [31:0] idx;
        logic [47:0] start_addr;
        logic [47:0] end_addr;
    } address_rule_48_t;

    typedef enum int unsigned {
        RegbusOutBootrom    = 0,
        RegbusOutCsr        = 1,
        RegbusOutLlc        = 2,
        RegbusOutSerialLink = 3,
        RegbusOutUart       = 4,
        RegbusOutI2c        = 5,
        RegbusOutSpim       = 6,
        RegbusOutVga        = 7,
        RegbusOutClint      = 8,
        RegbusOutPlic       = 9,
        RegbusOutExt        = 10
    } regbus_out_e;

    localparam int unsigned RegbusNumOut   = 11;
    localparam int unsigned RegbusNumRules = 11;

    typedef address_rule_48_t [RegbusNumRules-1:0] regbus_addr_map_t;

    function automatic address_rule_48_t make_rule(regbus_out_e idx, logic [47:0] start_addr,
                                                   logic [47:0] end_addr);
        address_rule_48_t r;
        r.idx        = 32'(idx);
        r.start_addr = start_addr;
        r.end_addr   = end_addr;
        return r;
    endfunction

    // End addresses are exclusive.
    function automatic regbus_addr_map_t regbus_addr_map();
        regbus_addr_map_t m;
        m[0]  = make_rule(RegbusOutBootrom,    48'h0000_0100_0000, 48'h0000_0102_0000);
        m[1]  = make_rule(RegbusOutCsr,        48'h0000_0200_0000, 48'h0000_0200_1000);
        m[2]  = make_rule(RegbusOutLlc,        48'h0000_0200_1000, 48'h0000_0200_2000);
        m[3]  = make_rule(RegbusOutSerialLink, 48'h0000_0200_2000, 48'h0000_0200_3000);
        m[4]  = make_rule(RegbusOutUart,       48'h0000_0200_3000, 48'h0000_0200_4000);
        m[5]  = make_rule(RegbusOutI2c,        48'h0000_0200_4000, 48'h0000_0200_5000);
        m[6]  = make_rule(RegbusOutSpim,       48'h0000_0200_5000, 48'h0000_0200_6000);
        m[7]  = make_rule(RegbusOutVga,        48'h0000_0200_6000, 48'h0000_0200_7000);
        m[8]  = make_rule(RegbusOutClint,      48'h0000_0400_0000, 48'h0000_0410_0000);
        m[9]  = make_rule(RegbusOutPlic,       48'h0000_0C00_0000, 48'h0000_1000_0000);
        m[10] = make_rule(RegbusOutExt,        48'h0000_2000_0000, 48'h0000_4000_0000);
        return m;
    endfunction

    localparam regbus_addr_map_t RegbusAddrMap = regbus_addr_map();

    // Read data returned when a target never answers.
    localparam logic [31:0] RegbusTimeoutRdata    = 32'hBADCAB1E;
    localparam int unsigned RegbusArbTimeoutCycles = 1024;

endpackage

// File: rtl/cheshire_rr_picker.sv
// Combinational round-robin picker: first set request searching upward from ptr+1 (wrapping).
module cheshire_rr_picker #(
    parameter int unsigned NumReq   = 2,
    parameter int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0]   req,
    input  logic [IdxWidth-1:0] ptr,
    output logic [IdxWidth-1:0] idx,
    output logic                any_valid
);

    logic [IdxWidth-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest set request is the last one written.
    always_comb begin
        idx       = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = int'(NumReq); k >= 1; k--) begin
            cand = IdxWidth'((int'(ptr) + k) % int'(NumReq));
            if (req[cand]) begin
                idx       = cand;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cheshire_regbus_arbiter.sv
// Round-robin regbus arbiter with address decode, decode-error and target-timeout responses.
module cheshire_regbus_arbiter
    import cheshire_pkg::*;
#(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned NumTgt        = RegbusNumOut,
    parameter int unsigned NumRules      = RegbusNumRules,
    parameter int unsigned AddrWidth     = RegbusAddrWidth,
    parameter int unsigned DataWidth     = RegbusDataWidth,
    parameter int unsigned TimeoutCycles = RegbusArbTimeoutCycles,
    parameter address_rule_48_t [NumRules-1:0] AddrMap = RegbusAddrMap
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumReq-1:0]               req_valid_i,
    input  logic [NumReq-1:0]               req_write_i,
    input  logic [NumReq*AddrWidth-1:0]     req_addr_i,
    input  logic [NumReq*DataWidth-1:0]     req_wdata_i,
    input  logic [NumReq*DataWidth/8-1:0]   req_wstrb_i,
    output logic [NumReq-1:0]               req_ready_o,
    output logic [NumReq*DataWidth-1:0]     req_rdata_o,
    output logic [NumReq-1:0]               req_error_o,
    output logic [NumTgt-1:0]               tgt_valid_o,
    output logic                            tgt_write_o,
    output logic [AddrWidth-1:0]            tgt_addr_o,
    output logic [DataWidth-1:0]            tgt_wdata_o,
    output logic [DataWidth/8-1:0]          tgt_wstrb_o,
    input  logic [NumTgt-1:0]               tgt_ready_i,
    input  logic [NumTgt*DataWidth-1:0]     tgt_rdata_i,
    input  logic [NumTgt-1:0]               tgt_error_i,
    output logic                            busy_o
);

    localparam int unsigned ReqIdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned TgtIdxW = (NumTgt > 1) ? $clog2(NumTgt) : 1;
    localparam int unsigned CntW    = $clog2(TimeoutCycles);
    localparam int unsigned StrbW   = DataWidth / 8;

    typedef enum logic [1:0] {StIdle, StBusy, StDecErr} state_e;

    state_e              state_q, state_d;
    logic [ReqIdxW-1:0]  ptr_q, ptr_d;
    logic [ReqIdxW-1:0]  grant_q, grant_d;
    logic [TgtIdxW-1:0]  tgt_q, tgt_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    logic [ReqIdxW-1:0]  pick_idx;
    logic                pick_any;
    logic                dec_hit;
    logic [TgtIdxW-1:0]  dec_idx;

    logic [AddrWidth-1:0] addr_arr  [NumReq];
    logic [DataWidth-1:0] wdata_arr [NumReq];
    logic [StrbW-1:0]     wstrb_arr [NumReq];
    logic [DataWidth-1:0] rsp_rdata [NumReq];
    logic [DataWidth-1:0] trd_arr   [NumTgt];

    for (genvar r = 0; r < NumReq; r++) begin : g_req
        assign addr_arr[r]  = req_addr_i[r*AddrWidth +: AddrWidth];
        assign wdata_arr[r] = req_wdata_i[r*DataWidth +: DataWidth];
        assign wstrb_arr[r] = req_wstrb_i[r*StrbW +: StrbW];
        assign req_rdata_o[r*DataWidth +: DataWidth] = rsp_rdata[r];
    end

    for (genvar t = 0; t < NumTgt; t++) begin : g_tgt
        assign trd_arr[t] = tgt_rdata_i[t*DataWidth +: DataWidth];
    end

    cheshire_rr_picker #(
        .NumReq   (NumReq),
        .IdxWidth (ReqIdxW)
    ) u_picker (
        .req       (req_valid_i),
        .ptr       (ptr_q),
        .idx       (pick_idx),
        .any_valid (pick_any)
    );

    // Decode the candidate's address; iterating downward lets the lowest matching rule win.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = int'(NumRules) - 1; i >= 0; i--) begin
            if ((AddrMap[i].idx < 32'(NumTgt)) &&
                (addr_arr[pick_idx] >= AddrWidth'(AddrMap[i].start_addr)) &&
                (addr_arr[pick_idx] <  AddrWidth'(AddrMap[i].end_addr))) begin
                dec_hit = 1'b1;
                dec_idx = TgtIdxW'(AddrMap[i].idx);
            end
        end
    end

    // Next-state and output logic; everything is forced to zero while in reset.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;

        req_ready_o = '0;
        req_error_o = '0;
        for (int r = 0; r < int'(NumReq); r++) begin
            rsp_rdata[r] = '0;
        end
        tgt_valid_o = '0;
        tgt_write_o = 1'b0;
        tgt_addr_o  = '0;
        tgt_wdata_o = '0;
        tgt_wstrb_o = '0;
        busy_o      = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (pick_any) begin
                    grant_d = pick_idx;
                    tgt_d   = dec_idx;
                    state_d = dec_hit ? StBusy : StDecErr;
                end
            end
            StBusy: begin
                busy_o      = 1'b1;
                tgt_write_o = req_write_i[grant_q];
                tgt_addr_o  = addr_arr[grant_q];
                tgt_wdata_o = wdata_arr[grant_q];
                tgt_wstrb_o = wstrb_arr[grant_q];
                if (tgt_ready_i[tgt_q]) begin
                    // Target response passes straight through in its ready cycle.
                    tgt_valid_o[tgt_q]   = 1'b1;
                    req_ready_o[grant_q] = 1'b1;
                    req_error_o[grant_q] = tgt_error_i[tgt_q];
                    rsp_rdata[grant_q]   = trd_arr[tgt_q];
                    ptr_d   = grant_q;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                    req_ready_o[grant_q] = 1'b1;
                    req_error_o[grant_q] = 1'b1;
                    rsp_rdata[grant_q]   = DataWidth'(RegbusTimeoutRdata);
                    ptr_d   = grant_q;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    tgt_valid_o[tgt_q] = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDecErr: begin
                busy_o               = 1'b1;
                req_ready_o[grant_q] = 1'b1;
                req_error_o[grant_q] = 1'b1;
                ptr_d   = grant_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (rst_i) begin
            req_ready_o = '0;
            req_error_o = '0;
            for (int r = 0; r < int'(NumReq); r++) begin
                rsp_rdata[r] = '0;
            end
            tgt_valid_o = '0;
            tgt_write_o = 1'b0;
            tgt_addr_o  = '0;
            tgt_wdata_o = '0;
            tgt_wstrb_o = '0;
            busy_o      = 1'b0;
        end
    end

    // State registers; pointer resets to the last requester so requester 0 wins first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ptr_q   <= ReqIdxW'(NumReq - 1);
            grant_q <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    // A requester must hold valid until it sees its ready pulse.
    assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q != StIdle) |-> req_valid_i[grant_q])
        else $error("regbus requester dropped valid before ready");

endmodule

// File: tb/tb_cheshire_regbus_arbiter.sv
// Directed bench for cheshire_regbus_arbiter: vector table plus fairness and reset sequences.
module tb_cheshire_regbus_arbiter;

    localparam int NR = 2;
    localparam int NT = 11;
    localparam int AW = 48;
    localparam int DW = 32;
    localparam int TO = 1024;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NR-1:0]      req_valid = '0;
    logic [NR-1:0]      req_write = '0;
    logic [NR*AW-1:0]   req_addr  = '0;
    logic [NR*DW-1:0]   req_wdata = '0;
    logic [NR*4-1:0]    req_wstrb = '0;
    logic [NR-1:0]      req_ready;
    logic [NR*DW-1:0]   req_rdata;
    logic [NR-1:0]      req_error;
    logic [NT-1:0]      tgt_valid;
    logic               tgt_write;
    logic [AW-1:0]      tgt_addr;
    logic [DW-1:0]      tgt_wdata;
    logic [3:0]         tgt_wstrb;
    logic [NT-1:0]      tgt_ready = '0;
    logic [NT*DW-1:0]   tgt_rdata = '0;
    logic [NT-1:0]      tgt_error = '0;
    logic               busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cheshire_regbus_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_wstrb_i (req_wstrb),
        .req_ready_o (req_ready),
        .req_rdata_o (req_rdata),
        .req_error_o (req_error),
        .tgt_valid_o (tgt_valid),
        .tgt_write_o (tgt_write),
        .tgt_addr_o  (tgt_addr),
        .tgt_wdata_o (tgt_wdata),
        .tgt_wstrb_o (tgt_wstrb),
        .tgt_ready_i (tgt_ready),
        .tgt_rdata_i (tgt_rdata),
        .tgt_error_i (tgt_error),
        .busy_o      (busy)
    );

    typedef struct {
        int          req;
        bit          write;
        logic [47:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          tgt;      // -1: expected decode miss
        int          delay;    // BUSY cycles without ready before the target answers
        logic [31:0] trdata;
        bit          terr;
        int          lat;      // cycle of req_ready, valid raised in cycle 1
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          vcnt;     // cycles with tgt_valid set on the decoded target
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit outs_zero();
        return (req_ready == '0) && (req_rdata == '0) && (req_error == '0) &&
               (tgt_valid == '0) && (tgt_write == 1'b0) && (tgt_addr == '0) &&
               (tgt_wdata == '0) && (tgt_wstrb == '0) && (busy == 1'b0);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        tgt_ready = '0;
        @(negedge clk);
        #1 check("reset_outputs_zero", 64'(outs_zero()), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        #1 check("idle_outputs_zero", 64'(outs_zero()), 64'd1);
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int          got_cyc = 0;
        int          vcnt = 0;
        int          stray = 0;
        int          badpay = 0;
        logic [31:0] got_rdata = '0;
        logic        got_err = 1'b0;
        string       tag;
        tag = $sformatf("v%0d", id);
        @(negedge clk);
        req_valid[v.req] = 1'b1;
        req_write[v.req] = v.write;
        req_addr[v.req*AW +: AW]  = v.addr;
        req_wdata[v.req*DW +: DW] = v.wdata;
        req_wstrb[v.req*4 +: 4]   = v.wstrb;
        for (int c = 1; c <= 1200 && got_cyc == 0; c++) begin
            if (c > 1) @(negedge clk);
            tgt_ready = '0;
            tgt_rdata = '0;
            tgt_error = '0;
            if (v.tgt >= 0 && c == v.delay + 2) begin
                tgt_ready[v.tgt] = 1'b1;
                tgt_rdata[v.tgt*DW +: DW] = v.trdata;
                tgt_error[v.tgt] = v.terr;
            end
            #1;
            for (int t = 0; t < NT; t++) begin
                if (tgt_valid[t]) begin
                    if (t == v.tgt) begin
                        vcnt++;
                        if (tgt_write !== v.write || tgt_addr !== v.addr ||
                            tgt_wdata !== v.wdata || tgt_wstrb !== v.wstrb) badpay++;
                    end else begin
                        stray++;
                    end
                end
            end
            if (req_ready[1-v.req]) stray++;
            if (req_ready[v.req]) begin
                got_cyc   = c;
                got_rdata = req_rdata[v.req*DW +: DW];
                got_err   = req_error[v.req];
            end
        end
        @(negedge clk);
        req_valid = '0;
        tgt_ready = '0;
        tgt_rdata = '0;
        tgt_error = '0;
        #1;
        check({tag, "_latency"}, 64'(got_cyc), 64'(v.lat));
        check({tag, "_rdata"}, 64'(got_rdata), 64'(v.exp_rdata));
        check({tag, "_error"}, 64'(got_err), 64'(v.exp_err));
        check({tag, "_tgt_valid_cycles"}, 64'(vcnt), 64'(v.vcnt));
        check({tag, "_stray"}, 64'(stray), 64'd0);
        check({tag, "_payload"}, 64'(badpay), 64'd0);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    int grants [8];
    int ng;

    initial begin
        //            req wr addr                 wdata         strb  tgt delay   trdata        terr lat  exp_rdata    err vcnt
        vecs[0] = '{0, 1, 48'h0000_0200_0000, 32'h1234_5678, 4'hF, 1,  0,      32'h0,        0, 2,    32'h0,        0, 1};
        vecs[1] = '{1, 0, 48'h0000_0200_3010, 32'h0,         4'h0, 4,  3,      32'h41,       0, 5,    32'h41,       0, 4};
        vecs[2] = '{0, 0, 48'h0000_0200_8000, 32'h0,         4'h0, -1, 0,      32'h0,        0, 2,    32'h0,        1, 0};
        vecs[3] = '{0, 0, 48'h0000_0102_0000, 32'h0,         4'h0, -1, 0,      32'h0,        0, 2,    32'h0,        1, 0};
        vecs[4] = '{1, 0, 48'h0000_0100_0000, 32'h0,         4'h0, 0,  1,      32'hDEADBEEF, 0, 3,    32'hDEADBEEF, 0, 2};
        vecs[5] = '{0, 0, 48'h0000_0101_FFFC, 32'h0,         4'h0, 0,  0,      32'hCAFEF00D, 0, 2,    32'hCAFEF00D, 0, 1};
        vecs[6] = '{1, 1, 48'h0000_0200_4000, 32'h0000_A5A5, 4'h3, 5,  2,      32'h55,       1, 4,    32'h55,       1, 3};
        vecs[7] = '{0, 0, 48'h0000_0C00_0000, 32'h0,         4'h0, 9,  100000, 32'h0,        0, TO+1, 32'hBADCAB1E, 1, TO-1};
        vecs[8] = '{1, 0, 48'h0000_2000_0000, 32'h0,         4'h0, 10, 0,      32'h0BAD_F00D, 0, 2,   32'h0BAD_F00D, 0, 1};

        apply_reset();

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // Fairness: both requesters hammer the CLINT, which is always ready.
        apply_reset();
        @(negedge clk);
        tgt_ready[8] = 1'b1;
        req_addr[0 +: AW]  = 48'h0000_0400_0000;
        req_addr[AW +: AW] = 48'h0000_0400_0004;
        req_valid = 2'b11;
        ng = 0;
        for (int c = 0; c < 40 && ng < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (req_ready != '0) begin
                check("fair_onehot", 64'($countones(req_ready)), 64'd1);
                grants[ng] = req_ready[1] ? 1 : 0;
                check("fair_tgt_addr", 64'(tgt_addr), req_ready[1] ? 64'h0400_0004 : 64'h0400_0000);
                ng++;
            end
        end
        @(negedge clk);
        req_valid = '0;
        tgt_ready = '0;
        check("fair_count", 64'(ng), 64'd8);
        for (int k = 0; k < ng; k++) begin
            check($sformatf("fair_grant%0d", k), 64'(grants[k]), 64'(k % 2));
        end

        // Reset in the middle of a hung PLIC access.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0 +: AW] = 48'h0000_0C00_0000;
        repeat (5) @(negedge clk);
        #1 check("midop_busy", 64'(busy), 64'd1);
        check("midop_tgt_valid", 64'(tgt_valid), 64'h200);
        rst = 1'b1;
        #1 check("midop_reset_outputs_zero", 64'(outs_zero()), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        #1 check("after_reset_outputs_zero", 64'(outs_zero()), 64'd1);
        // A full timeout afterwards proves the counter restarted.
        run_vec(9, vecs[7]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
